lsu_seq: RTL and testbench

- Load/store sequencer between the execute stage and the single-port data memory.
- Accepts one load or store per handshake and drives the memory request/grant/rvalid protocol.
- Stores: generates byte enables and lane-aligned write data. Loads: byte-lane alignment plus sign/zero extension.
- Misaligned accesses crossing a word boundary are split into two word accesses, or rejected when splitting is disabled.

---
 rtl/lsu_seq.sv | 270 +++++++++++++++++++++++++++
 tb/tb_lsu_seq.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_seq.sv
// Load/store sequencer between the execute stage and a single-port data memory.
// Accepts one load or store at a time. It drives the memory req/gnt/rvalid
// protocol and generates lane-aligned byte enables and write data.
// Loads are aligned back to bit 0 and then sign- or zero-extended.
// An access that crosses a word boundary is either split into two word
// accesses (SPLIT_EN=1) or rejected with resp_err (SPLIT_EN=0).
//
// Handshakes:
//  - A request is accepted on a cycle where req_valid & req_ready are both high.
//  - mem_req is held, and every mem_* output stays stable, until the cycle mem_gnt is seen.
//  - The bus has one transaction outstanding at most. mem_rvalid is only
//    honoured while waiting for it and is ignored in every other state.
//  - resp_valid is a single-cycle pulse. req_ready returns the cycle after it.
module lsu_seq #(
    parameter bit SPLIT_EN = 1'b1,
    parameter int ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [1:0]        req_size,
    input  logic              req_unsign,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_req,
    input  logic              mem_gnt,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE0 = 3'd1,
        S_WAIT0  = 3'd2,
        S_ISSUE1 = 3'd3,
        S_WAIT1  = 3'd4,
        S_RESP   = 3'd5
    } state_e;

    state_e state_q, state_d;

    // Request fields that are still needed after the accept cycle
    logic [1:0]        off_q, off_d;
    logic [1:0]        size_q, size_d;
    logic              unsign_q, unsign_d;
    logic              split_q, split_d;
    logic [3:0]        be1_q, be1_d;
    logic [31:0]       wdata1_q, wdata1_d;
    logic [31:0]       rdata0_q, rdata0_d;

    // Registered outputs
    logic              ready_q, ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic [31:0]       resp_rdata_q, resp_rdata_d;
    logic              resp_err_q, resp_err_d;
    logic              mem_req_q, mem_req_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_we_q, mem_we_d;
    logic [3:0]        mem_be_q, mem_be_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;

    // Request decode: lane mask and data pre-shifted across an 8-lane window.
    // The low half feeds access 0 and the high half feeds access 1.
    logic [3:0]  req_mask;
    logic [7:0]  req_be_ext;
    logic [63:0] req_wd_ext;
    logic        req_cross;

    // Byte-count mask for the requested size (size 11 behaves as a word)
    always_comb begin
        unique case (req_size)
            2'b00:   req_mask = 4'b0001;
            2'b01:   req_mask = 4'b0011;
            default: req_mask = 4'b1111;
        endcase
    end

    assign req_be_ext = {4'b0000, req_mask} << req_addr[1:0];
    assign req_wd_ext = {32'h0, req_wdata} << {req_addr[1:0], 3'b000};
    assign req_cross  = |req_be_ext[7:4];

    // Load merge: the bytes of interest start at lane off of the first word.
    // For a split access they continue into the low lanes of the second word.
    logic [55:0] merge_src;
    logic [31:0] merged;
    logic [31:0] load_ext;

    // Select the merge window for the current completion and drop off bytes
    always_comb begin
        merge_src = (state_q == S_WAIT1) ? {mem_rdata[23:0], rdata0_q}
                                         : {24'h0, mem_rdata};
        unique case (off_q)
            2'd0:    merged = merge_src[31:0];
            2'd1:    merged = merge_src[39:8];
            2'd2:    merged = merge_src[47:16];
            default: merged = merge_src[55:24];
        endcase
    end

    // Sign/zero extension of byte and half loads; word loads pass through
    always_comb begin
        unique case (size_q)
            2'b00:   load_ext = {{24{~unsign_q & merged[7]}}, merged[7:0]};
            2'b01:   load_ext = {{16{~unsign_q & merged[15]}}, merged[15:0]};
            default: load_ext = merged;
        endcase
    end

    // Next-state and next-output logic for the sequencer
    always_comb begin
        state_d      = state_q;
        off_d        = off_q;
        size_d       = size_q;
        unsign_d     = unsign_q;
        split_d      = split_q;
        be1_d        = be1_q;
        wdata1_d     = wdata1_q;
        rdata0_d     = rdata0_q;
        ready_d      = ready_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        mem_req_d    = mem_req_q;
        mem_addr_d   = mem_addr_q;
        mem_we_d     = mem_we_q;
        mem_be_d     = mem_be_q;
        mem_wdata_d  = mem_wdata_q;

        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    off_d    = req_addr[1:0];
                    size_d   = req_size;
                    unsign_d = req_unsign;
                    split_d  = req_cross & SPLIT_EN;
                    be1_d    = req_be_ext[7:4];
                    wdata1_d = req_wd_ext[63:32];
                    ready_d  = 1'b0;
                    if (req_cross && !SPLIT_EN) begin
                        // Rejected: answer immediately, memory never sees it
                        state_d      = S_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = 32'h0;
                    end else begin
                        state_d     = S_ISSUE0;
                        mem_req_d   = 1'b1;
                        mem_addr_d  = {req_addr[ADDR_W-1:2], 2'b00};
                        mem_we_d    = req_we;
                        mem_be_d    = req_be_ext[3:0];
                        mem_wdata_d = req_wd_ext[31:0];
                    end
                end
            end
            S_ISSUE0: begin
                if (mem_gnt) begin
                    mem_req_d = 1'b0;
                    state_d   = S_WAIT0;
                end
            end
            S_WAIT0: begin
                if (mem_rvalid) begin
                    if (split_q) begin
                        rdata0_d    = mem_rdata;
                        state_d     = S_ISSUE1;
                        mem_req_d   = 1'b1;
                        // Word address increment wraps at the top of the space
                        mem_addr_d  = mem_addr_q + ADDR_W'(4);
                        mem_be_d    = be1_q;
                        mem_wdata_d = wdata1_q;
                    end else begin
                        state_d      = S_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b0;
                        resp_rdata_d = mem_we_q ? 32'h0 : load_ext;
                    end
                end
            end
            S_ISSUE1: begin
                if (mem_gnt) begin
                    mem_req_d = 1'b0;
                    state_d   = S_WAIT1;
                end
            end
            S_WAIT1: begin
                if (mem_rvalid) begin
                    state_d      = S_RESP;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b0;
                    resp_rdata_d = mem_we_q ? 32'h0 : load_ext;
                end
            end
            S_RESP: begin
                state_d      = S_IDLE;
                resp_valid_d = 1'b0;
                resp_err_d   = 1'b0;
                resp_rdata_d = 32'h0;
                ready_d      = 1'b1;
            end
            default: begin
                state_d      = S_IDLE;
                ready_d      = 1'b1;
                resp_valid_d = 1'b0;
                resp_err_d   = 1'b0;
                mem_req_d    = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops mem_req and returns to IDLE at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            off_q        <= 2'd0;
            size_q       <= 2'd0;
            unsign_q     <= 1'b0;
            split_q      <= 1'b0;
            be1_q        <= 4'h0;
            wdata1_q     <= 32'h0;
            rdata0_q     <= 32'h0;
            ready_q      <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            mem_we_q     <= 1'b0;
            mem_be_q     <= 4'h0;
            mem_wdata_q  <= 32'h0;
        end else begin
            state_q      <= state_d;
            off_q        <= off_d;
            size_q       <= size_d;
            unsign_q     <= unsign_d;
            split_q      <= split_d;
            be1_q        <= be1_d;
            wdata1_q     <= wdata1_d;
            rdata0_q     <= rdata0_d;
            ready_q      <= ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
            mem_we_q     <= mem_we_d;
            mem_be_q     <= mem_be_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign req_ready  = ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign mem_req    = mem_req_q;
    assign mem_addr   = mem_addr_q;
    assign mem_we     = mem_we_q;
    assign mem_be     = mem_be_q;
    assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_lsu_seq.sv
// Bench for lsu_seq. dut1 splits word-crossing accesses and dut0 rejects them.
// A reactive memory serves dut1 with programmable grant/rvalid delays.
// A byte-addressed reference memory predicts every load result.
module tb_lsu_seq;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- DUT wiring ----------------
    logic        req_valid1, req_valid0;
    logic        req_we;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        req_unsign;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;
    logic        mem_gnt0, mem_rvalid0;
    logic [31:0] mem_rdata0;

    logic        req_ready1, resp_valid1, resp_err1, mem_req1, mem_we1;
    logic [31:0] resp_rdata1, mem_addr1, mem_wdata1;
    logic [3:0]  mem_be1;
    logic        req_ready0, resp_valid0, resp_err0, mem_req0, mem_we0;
    logic [31:0] resp_rdata0, mem_addr0, mem_wdata0;
    logic [3:0]  mem_be0;

    lsu_seq #(.SPLIT_EN(1'b1), .ADDR_W(32)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid1), .req_ready(req_ready1), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_unsign(req_unsign),
        .resp_valid(resp_valid1), .resp_rdata(resp_rdata1), .resp_err(resp_err1),
        .mem_req(mem_req1), .mem_gnt(mem_gnt), .mem_addr(mem_addr1),
        .mem_we(mem_we1), .mem_be(mem_be1), .mem_wdata(mem_wdata1),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    lsu_seq #(.SPLIT_EN(1'b0), .ADDR_W(32)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid0), .req_ready(req_ready0), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_unsign(req_unsign),
        .resp_valid(resp_valid0), .resp_rdata(resp_rdata0), .resp_err(resp_err0),
        .mem_req(mem_req0), .mem_gnt(mem_gnt0), .mem_addr(mem_addr0),
        .mem_we(mem_we0), .mem_be(mem_be0), .mem_wdata(mem_wdata0),
        .mem_rvalid(mem_rvalid0), .mem_rdata(mem_rdata0)
    );

    // ---------------- scoreboard state ----------------
    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
    } acc_t;
    acc_t acc_q[$];

    logic [31:0] wmem [logic [31:0]];   // memory as seen by the DUT (word addressed)
    logic [7:0]  bmem [logic [31:0]];   // reference memory (byte addressed)

    int gnt_dly = 0;
    int rv_dly  = 1;
    bit in_rst_test = 1'b0;
    int mem_req0_cnt = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        return wmem.exists(a) ? wmem[a] : 32'h0;
    endfunction

    function automatic logic [7:0] rd_byte(input logic [31:0] a);
        return bmem.exists(a) ? bmem[a] : 8'h0;
    endfunction

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    task automatic set_word(input logic [31:0] a, input logic [31:0] w);
        logic [31:0] ba;
        wmem[a] = w;
        for (int k = 0; k < 4; k++) begin
            ba = a + k;
            bmem[ba] = w[8*k +: 8];
        end
    endtask

    // Reference load: gather n consecutive bytes (address wraps), then extend
    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz,
                                             input logic uns);
        int n;
        logic [31:0] v;
        logic [31:0] ba;
        n = nbytes(sz);
        v = 32'h0;
        for (int k = 0; k < n; k++) begin
            ba = a + k;
            v[8*k +: 8] = rd_byte(ba);
        end
        if (!uns && n < 4)
            for (int b = 8*n; b < 32; b++) v[b] = v[8*n-1];
        return v;
    endfunction

    task automatic ref_store(input logic [31:0] a, input logic [31:0] wd, input int n);
        logic [31:0] ba;
        for (int k = 0; k < n; k++) begin
            ba = a + k;
            bmem[ba] = wd[8*k +: 8];
        end
    endtask

    // ---------------- memory responder for dut1 ----------------
    task automatic serve_one();
        acc_t snap;
        logic [31:0] w;
        snap.addr  = mem_addr1;
        snap.be    = mem_be1;
        snap.we    = mem_we1;
        snap.wdata = mem_wdata1;
        for (int i = 0; i < gnt_dly; i++) begin
            @(negedge clk);
            check("stall_req",   mem_req1,   1);
            check("stall_addr",  mem_addr1,  snap.addr);
            check("stall_be",    mem_be1,    snap.be);
            check("stall_we",    mem_we1,    snap.we);
            check("stall_wdata", mem_wdata1, snap.wdata);
            check("stall_ready", req_ready1, 0);
        end
        mem_gnt = 1'b1;
        acc_q.push_back(snap);
        w = rd_word(snap.addr);
        if (snap.we) begin
            for (int k = 0; k < 4; k++)
                if (snap.be[k]) w[8*k +: 8] = snap.wdata[8*k +: 8];
            wmem[snap.addr] = w;
        end
        @(negedge clk);
        mem_gnt = 1'b0;
        for (int i = 1; i < rv_dly; i++) begin
            @(negedge clk);
            if (!in_rst_test) check("rwait_ready", req_ready1, 0);
        end
        mem_rvalid = 1'b1;
        mem_rdata  = w;
        @(negedge clk);
        mem_rvalid = 1'b0;
        mem_rdata  = $urandom();
    endtask

    initial begin
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            while (rst_n && mem_req1) serve_one();
        end
    end

    // dut0 must never touch memory
    always @(negedge clk) if (mem_req0) mem_req0_cnt++;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver ----------------
    task automatic do_req(input bit sel0, input logic we, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [1:0] size, input logic uns,
                          output int lat, output logic [31:0] rd, output logic err);
        @(negedge clk);
        req_we = we; req_addr = addr; req_wdata = wd; req_size = size; req_unsign = uns;
        check("req_ready", sel0 ? req_ready0 : req_ready1, 1);
        if (sel0) req_valid0 = 1'b1; else req_valid1 = 1'b1;
        lat = 0; rd = 'x; err = 'x;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            req_valid0 = 1'b0; req_valid1 = 1'b0;
            if (sel0 ? resp_valid0 : resp_valid1) begin
                lat = i;
                rd  = sel0 ? resp_rdata0 : resp_rdata1;
                err = sel0 ? resp_err0 : resp_err1;
                break;
            end
        end
        if (lat == 0) begin
            check("resp_timeout", 0, 1);
        end else begin
            @(negedge clk);
            check("resp_pulse", sel0 ? resp_valid0 : resp_valid1, 0);
            check("ready_back", sel0 ? req_ready0 : req_ready1, 1);
        end
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int lat;
        logic [31:0] rd;
        logic err;
        logic [31:0] wd, addr;
        logic [1:0] sz;
        logic we, uns;
        int n, off, nacc, cnt;

        rst_n = 1'b0;
        req_valid1 = 1'b0; req_valid0 = 1'b0;
        req_we = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; req_size = 2'b00; req_unsign = 1'b0;
        mem_gnt0 = 1'b0; mem_rvalid0 = 1'b0; mem_rdata0 = 32'h0;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_ready",  req_ready1,  1);
        check("rst_rvalid", resp_valid1, 0);
        check("rst_rdata",  resp_rdata1, 0);
        check("rst_err",    resp_err1,   0);
        check("rst_mreq",   mem_req1,    0);
        check("rst_maddr",  mem_addr1,   0);
        check("rst_mbe",    mem_be1,     0);
        check("rst_mwdata", mem_wdata1,  0);
        check("rst_ready0", req_ready0,  1);
        rst_n = 1'b1;
        @(negedge clk);

        // Aligned word load
        set_word(32'h100, 32'h8899AABB);
        acc_q.delete();
        do_req(0, 0, 32'h100, 32'h0, 2'b10, 0, lat, rd, err);
        check("wl_lat", lat, 3);
        check("wl_rdata", rd, 32'h8899AABB);
        check("wl_err", err, 0);
        check("wl_nacc", acc_q.size(), 1);
        check("wl_addr", acc_q[0].addr, 32'h100);
        check("wl_be", acc_q[0].be, 4'b1111);
        check("wl_we", acc_q[0].we, 0);

        // Byte / half loads with sign and zero extension
        set_word(32'h100, 32'h80FF7F01);
        acc_q.delete();
        do_req(0, 0, 32'h103, 32'h0, 2'b00, 0, lat, rd, err);
        check("lb_rdata", rd, 32'hFFFFFF80);
        check("lb_be", acc_q[0].be, 4'b1000);
        check("lb_addr", acc_q[0].addr, 32'h100);
        do_req(0, 0, 32'h103, 32'h0, 2'b00, 1, lat, rd, err);
        check("lbu_rdata", rd, 32'h00000080);
        do_req(0, 0, 32'h102, 32'h0, 2'b01, 0, lat, rd, err);
        check("lh_rdata", rd, 32'hFFFF80FF);

        // Split half store
        acc_q.delete();
        ref_store(32'h203, 32'h1234, 2);
        do_req(0, 1, 32'h203, 32'h1234, 2'b01, 0, lat, rd, err);
        check("sh_lat", lat, 5);
        check("sh_err", err, 0);
        check("sh_rdata", rd, 0);
        check("sh_nacc", acc_q.size(), 2);
        check("sh_a0_addr", acc_q[0].addr, 32'h200);
        check("sh_a0_be", acc_q[0].be, 4'b1000);
        check("sh_a0_wd", acc_q[0].wdata[31:24], 8'h34);
        check("sh_a0_we", acc_q[0].we, 1);
        check("sh_a1_addr", acc_q[1].addr, 32'h204);
        check("sh_a1_be", acc_q[1].be, 4'b0001);
        check("sh_a1_wd", acc_q[1].wdata[7:0], 8'h12);
        check("sh_mem0", rd_word(32'h200), 32'h34000000);
        check("sh_mem1", rd_word(32'h204), 32'h00000012);

        // Split word load across the top of the address space
        set_word(32'hFFFFFFFC, 32'hDDCC1111);
        set_word(32'h0, 32'h2222BBAA);
        acc_q.delete();
        do_req(0, 0, 32'hFFFFFFFE, 32'h0, 2'b10, 0, lat, rd, err);
        check("wrap_rdata", rd, 32'hBBAADDCC);
        check("wrap_lat", lat, 5);
        check("wrap_a0", acc_q[0].addr, 32'hFFFFFFFC);
        check("wrap_a1", acc_q[1].addr, 32'h0);
        check("wrap_be0", acc_q[0].be, 4'b1100);
        check("wrap_be1", acc_q[1].be, 4'b0011);

        // Grant stall of 5 cycles and rvalid 3 cycles after grant
        gnt_dly = 5; rv_dly = 3;
        wd = $urandom();
        acc_q.delete();
        ref_store(32'h104, wd, 4);
        do_req(0, 1, 32'h104, wd, 2'b11, 0, lat, rd, err);
        check("stall_lat", lat, 10);
        check("stall_mem", rd_word(32'h104), wd);
        check("stall_acc_wd", acc_q[0].wdata, wd);
        gnt_dly = 0; rv_dly = 1;

        // Rejection without splitting
        do_req(1, 0, 32'h1, 32'h0, 2'b10, 0, lat, rd, err);
        check("rej_lat", lat, 1);
        check("rej_err", err, 1);
        check("rej_rdata", rd, 0);
        check("rej_nomem", mem_req0_cnt, 0);

        // Reset while waiting on the second half of a split load
        set_word(32'h304, 32'h44332211);
        set_word(32'h308, 32'h88776655);
        in_rst_test = 1'b1; rv_dly = 6;
        acc_q.delete();
        @(negedge clk);
        req_we = 1'b0; req_addr = 32'h306; req_size = 2'b10; req_unsign = 1'b0;
        req_valid1 = 1'b1;
        @(negedge clk);
        req_valid1 = 1'b0;
        cnt = 0;
        while (acc_q.size() < 2 && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        check("rst_reach_wait1", acc_q.size(), 2);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_mreq", mem_req1, 0);
        check("mid_rst_ready", req_ready1, 1);
        check("mid_rst_maddr", mem_addr1, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (resp_valid1 || mem_req1) cnt++;
        end
        check("late_rvalid_ignored", cnt, 0);
        in_rst_test = 1'b0; rv_dly = 1;
        acc_q.delete();
        do_req(0, 0, 32'h308, 32'h0, 2'b10, 0, lat, rd, err);
        check("post_rst_rdata", rd, 32'h88776655);
        check("post_rst_lat", lat, 3);

        // Randomized mix against the byte-level reference
        for (int a = 32'h300; a < 32'h324; a += 4) set_word(a, $urandom());
        for (int t = 0; t < 80; t++) begin
            we   = 1'($urandom_range(0, 1));
            sz   = 2'($urandom_range(0, 3));
            uns  = 1'($urandom_range(0, 1));
            addr = 32'h300 + $urandom_range(0, 27);
            wd   = $urandom();
            gnt_dly = $urandom_range(0, 2);
            rv_dly  = $urandom_range(1, 3);
            n    = nbytes(sz);
            off  = int'(addr[1:0]);
            nacc = (off + n > 4) ? 2 : 1;
            exp_q.push_back(we ? 32'h0 : ref_load(addr, sz, uns));
            if (we) ref_store(addr, wd, n);
            acc_q.delete();
            do_req(0, we, addr, wd, sz, uns, lat, rd, err);
            check("rnd_rdata", rd, exp_q.pop_front());
            check("rnd_err", err, 0);
            check("rnd_lat", lat, 1 + nacc * (1 + gnt_dly + rv_dly));
            check("rnd_nacc", acc_q.size(), nacc);
            if (acc_q.size() > 0) check("rnd_addr0", acc_q[0].addr, {addr[31:2], 2'b00});
        end
        gnt_dly = 0; rv_dly = 1;
        for (int a = 32'h300; a < 32'h328; a++) begin
            logic [31:0] wa;
            logic [31:0] ww;
            wa = a;
            ww = rd_word({wa[31:2], 2'b00});
            check("rnd_mem", ww[8*wa[1:0] +: 8], rd_byte(wa));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
